output_mem_if: RTL

OUTPUT_MEM_IF -- requirements
Module: output_mem_if

---
 rtl/systolic_pkg.sv | 14 +
 rtl/lane_capture.sv | 39 +++
 rtl/output_mem_if.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared defaults and FSM state type for the systolic array output path.
package systolic_pkg;

    localparam int ACC_W_DEF     = 16;
    localparam int N_MACS_DEF    = 4;
    localparam int MEM_DEPTH_DEF = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/lane_capture.sv
// One MAC lane: holds its first result of the current row and flags re-captures.
module lane_capture
    import systolic_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    capture_en,
    input  logic                    clear,
    input  logic                    valid,
    input  logic signed [ACC_W-1:0] din,
    output logic                    flag,
    output logic signed [ACC_W-1:0] lane_val,
    output logic                    ovf
);

    logic                    flag_reg;
    logic signed [ACC_W-1:0] value_reg;

    // flag/lane_val include a capture happening this cycle so a row can
    // complete on the same edge its last lane arrives.
    assign flag     = flag_reg | (capture_en & valid);
    assign lane_val = flag_reg ? value_reg : din;
    assign ovf      = capture_en & valid & flag_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_reg  <= 1'b0;
            value_reg <= '0;
        end else if (clear) begin
            flag_reg  <= 1'b0;
        end else if (capture_en && valid && !flag_reg) begin
            flag_reg  <= 1'b1;
            value_reg <= din;
        end
    end

endmodule

// File: rtl/output_mem_if.sv
// Collects per-lane MAC results into packed rows and writes them to output BRAM.
// Optional ReLU on written lanes when OUTPUT_MEM_IF_RELU_EN is defined.
module output_mem_if
    import systolic_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int N_MACS    = N_MACS_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic [$clog2(MEM_DEPTH)-1:0]    base_addr,
    input  logic [$clog2(MEM_DEPTH):0]      num_words,
    input  logic signed [ACC_W-1:0]         acc_in_0,
    input  logic signed [ACC_W-1:0]         acc_in_1,
    input  logic signed [ACC_W-1:0]         acc_in_2,
    input  logic signed [ACC_W-1:0]         acc_in_3,
    input  logic [N_MACS-1:0]               valid_in,
    output logic [$clog2(MEM_DEPTH)-1:0]    bram_addr,
    output logic                            bram_en,
    output logic                            bram_we,
    output logic [N_MACS*ACC_W-1:0]         bram_din,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = AW + 1;

    state_t state_reg, state_next;

    logic [AW-1:0]           addr_reg;
    logic [CW-1:0]           words_left_reg;
    logic                    overflow_reg;
    logic [AW-1:0]           bram_addr_reg;
    logic                    bram_we_reg;
    logic [N_MACS*ACC_W-1:0] bram_din_reg;

    logic start_ok;
    logic capture_en;
    logic row_done;
    logic lane_clear;

    logic [N_MACS-1:0]       lane_flag;
    logic [N_MACS-1:0]       lane_ovf;
    logic signed [ACC_W-1:0] acc_arr  [N_MACS];
    logic signed [ACC_W-1:0] lane_val [N_MACS];
    logic [N_MACS*ACC_W-1:0] packed_word;

    assign lane_clear = row_done | abort | start_ok;

    genvar gi;
    generate
        for (gi = 0; gi < N_MACS; gi++) begin : g_lane
            if (gi == 0) begin : g_a0
                assign acc_arr[gi] = acc_in_0;
            end else if (gi == 1) begin : g_a1
                assign acc_arr[gi] = acc_in_1;
            end else if (gi == 2) begin : g_a2
                assign acc_arr[gi] = acc_in_2;
            end else if (gi == 3) begin : g_a3
                assign acc_arr[gi] = acc_in_3;
            end else begin : g_anone
                assign acc_arr[gi] = '0;
            end

            lane_capture #(
                .ACC_W (ACC_W)
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .capture_en (capture_en),
                .clear      (lane_clear),
                .valid      (valid_in[gi]),
                .din        (acc_arr[gi]),
                .flag       (lane_flag[gi]),
                .lane_val   (lane_val[gi]),
                .ovf        (lane_ovf[gi])
            );

`ifdef OUTPUT_MEM_IF_RELU_EN
            assign packed_word[gi*ACC_W +: ACC_W] =
                lane_val[gi][ACC_W-1] ? '0 : lane_val[gi];
`else
            assign packed_word[gi*ACC_W +: ACC_W] = lane_val[gi];
`endif
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Rows are only gathered while words remain; once the count hits zero the
    // final write (if any) is on the bus and the next edge moves to DONE.
    always_comb begin
        state_next = state_reg;
        start_ok   = 1'b0;
        capture_en = 1'b0;
        row_done   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    start_ok   = 1'b1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (words_left_reg == '0) begin
                    state_next = DONE;
                end else begin
                    capture_en = 1'b1;
                    row_done   = &lane_flag;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg       <= '0;
            words_left_reg <= '0;
            overflow_reg   <= 1'b0;
            bram_addr_reg  <= '0;
            bram_we_reg    <= 1'b0;
            bram_din_reg   <= '0;
        end else begin
            bram_we_reg <= row_done;
            if (row_done) begin
                bram_din_reg   <= packed_word;
                bram_addr_reg  <= addr_reg;
                addr_reg       <= (addr_reg == AW'(MEM_DEPTH - 1)) ? '0 : addr_reg + AW'(1);
                words_left_reg <= words_left_reg - CW'(1);
            end
            if (start_ok) begin
                addr_reg       <= base_addr;
                words_left_reg <= num_words;
            end
            if (start_ok) begin
                overflow_reg <= 1'b0;
            end else if (|lane_ovf) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign bram_addr = bram_addr_reg;
    assign bram_en   = bram_we_reg;
    assign bram_we   = bram_we_reg;
    assign bram_din  = bram_din_reg;
    assign overflow  = overflow_reg;

endmodule
